epwm_multi: RTL

EPWM_MULTI -- requirements
Module: epwm_multi

---
 rtl/epwm_multi.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/epwm_multi.sv
// Multi-channel enhanced PWM: shared up / up-down time base, double-buffered
// period and compare registers, and per-channel dead-band insertion.
module epwm_multi #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int DB_W   = 8
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              wr_en,
  input  logic [3:0]        wr_addr,
  input  logic [31:0]       wr_data,
  input  logic [3:0]        rd_addr,
  output logic [31:0]       rd_data,
  input  logic              sync_in,
  output logic [NUM_CH-1:0] pwm_a,
  output logic [NUM_CH-1:0] pwm_b,
  output logic              zero_evt,
  output logic              period_evt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [DB_W-1:0]  DB_ONE  = {{(DB_W-1){1'b0}}, 1'b1};

  logic [2:0]       ctrl_q, ctrl_d;
  logic [CNT_W-1:0] period_sh_q, period_sh_d, period_act_q, period_act_d;
  logic [DB_W-1:0]  db_q, db_d;
  logic [CNT_W-1:0] cmp_sh_q [NUM_CH];
  logic [CNT_W-1:0] cmp_sh_d [NUM_CH];
  logic [CNT_W-1:0] cmp_act_q [NUM_CH];
  logic [CNT_W-1:0] cmp_act_d [NUM_CH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic             zero_evt_q, zero_evt_d, period_evt_q, period_evt_d;
  logic             en, mode, sync_en, load_act;
  logic             unused_wr_bits;

  assign en       = ctrl_q[0];
  assign mode     = ctrl_q[1];
  assign sync_en  = ctrl_q[2];
  assign load_act = !en || (cnt_q == '0);
  assign unused_wr_bits = ^wr_data;

  // Register file: writes land in shadow copies; active copies only
  // follow the shadows at the counter's zero point (or while stopped).
  always_comb begin
    ctrl_d       = ctrl_q;
    period_sh_d  = period_sh_q;
    db_d         = db_q;
    period_act_d = load_act ? period_sh_q : period_act_q;
    for (int k = 0; k < NUM_CH; k++) begin
      cmp_sh_d[k]  = cmp_sh_q[k];
      cmp_act_d[k] = load_act ? cmp_sh_q[k] : cmp_act_q[k];
    end
    if (wr_en) begin
      case (wr_addr)
        4'd0:    ctrl_d      = wr_data[2:0];
        4'd1:    period_sh_d = wr_data[CNT_W-1:0];
        4'd2:    db_d        = wr_data[DB_W-1:0];
        default: begin
          for (int k = 0; k < NUM_CH; k++) begin
            if (wr_addr == 4'(4 + k)) cmp_sh_d[k] = wr_data[CNT_W-1:0];
          end
        end
      endcase
    end
  end

  always_comb begin
    rd_data_d = '0;
    case (rd_addr)
      4'd0:    rd_data_d = 32'(ctrl_q);
      4'd1:    rd_data_d = 32'(period_sh_q);
      4'd2:    rd_data_d = 32'(db_q);
      4'd3:    rd_data_d = 32'(cnt_q);
      default: begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (rd_addr == 4'(4 + k)) rd_data_d = 32'(cmp_sh_q[k]);
        end
      end
    endcase
  end

  // Time base. dir_q: 0 = counting up, 1 = counting down.
  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (!en || (sync_en && sync_in)) begin
      cnt_d = '0;
      dir_d = 1'b0;
    end else if (!mode) begin
      dir_d = 1'b0;
      cnt_d = (cnt_q >= period_act_q) ? '0 : cnt_q + CNT_ONE;
    end else if (period_act_q == '0) begin
      cnt_d = '0;
      dir_d = 1'b0;
    end else if ((!dir_q && cnt_q < period_act_q) || cnt_q == '0) begin
      cnt_d = cnt_q + CNT_ONE;
      dir_d = 1'b0;
    end else begin
      // Turning around at 1 keeps zero a single-cycle point of the cycle.
      cnt_d = cnt_q - CNT_ONE;
      dir_d = (cnt_q != CNT_ONE);
    end
    zero_evt_d   = en && (cnt_q == '0);
    period_evt_d = en && (cnt_q == period_act_q);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      ctrl_q       <= '0;
      period_sh_q  <= '0;
      period_act_q <= '0;
      db_q         <= '0;
      cnt_q        <= '0;
      dir_q        <= 1'b0;
      rd_data_q    <= '0;
      zero_evt_q   <= 1'b0;
      period_evt_q <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        cmp_sh_q[k]  <= '0;
        cmp_act_q[k] <= '0;
      end
    end else begin
      ctrl_q       <= ctrl_d;
      period_sh_q  <= period_sh_d;
      period_act_q <= period_act_d;
      db_q         <= db_d;
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      rd_data_q    <= rd_data_d;
      zero_evt_q   <= zero_evt_d;
      period_evt_q <= period_evt_d;
      for (int k = 0; k < NUM_CH; k++) begin
        cmp_sh_q[k]  <= cmp_sh_d[k];
        cmp_act_q[k] <= cmp_act_d[k];
      end
    end
  end

  assign rd_data    = rd_data_q;
  assign zero_evt   = zero_evt_q;
  assign period_evt = period_evt_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic            raw;
      logic            raw_prev_q, raw_prev_d;
      logic [DB_W-1:0] rem_q, rem_d;
      logic            a_q, a_d, b_q, b_d;

      assign raw = (cnt_q < cmp_act_q[gi]);

      // rem_q counts the remaining dead cycles after the one already
      // scheduled; any edge of raw restarts it.
      always_comb begin
        raw_prev_d = raw;
        rem_d      = '0;
        a_d        = 1'b0;
        b_d        = 1'b0;
        if (!en) begin
          raw_prev_d = 1'b0;
        end else if (raw != raw_prev_q && db_q != '0) begin
          rem_d = db_q;
        end else if (rem_q > DB_ONE) begin
          rem_d = rem_q - DB_ONE;
        end else begin
          a_d = raw;
          b_d = !raw;
        end
      end

      always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
          raw_prev_q <= 1'b0;
          rem_q      <= '0;
          a_q        <= 1'b0;
          b_q        <= 1'b0;
        end else begin
          raw_prev_q <= raw_prev_d;
          rem_q      <= rem_d;
          a_q        <= a_d;
          b_q        <= b_d;
        end
      end

      assign pwm_a[gi] = a_q;
      assign pwm_b[gi] = b_q;
    end
  endgenerate

endmodule
